demux_lane_deserializer: RTL and testbench

- Sits directly downstream of the 1:4 demux. Consumes its 4-bit lane output and the select used to route each bit.
- Assembles each lane's serial bit stream into WIDTH-bit words, MSB first.
- Buffers one completed word per lane.
- Presents the buffered words on a single valid/ready output port, arbitrated round-robin across lanes.

---
 rtl/demux_deser_pkg.sv | 9 +
 rtl/deser_rr_arbiter.sv | 56 +++++
 rtl/demux_lane_deserializer.sv | 126 ++++++++++++
 tb/tb_demux_lane_deserializer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/demux_deser_pkg.sv
// Shared lane constants and the lane index type for the demux deserializer.
// Pure declarations: no latency or flow control of its own.
// Imported by the deserializer top and its round-robin arbiter.
package demux_deser_pkg;
    localparam int LANES  = 4;
    localparam int LANE_W = 2;

    typedef logic [LANE_W-1:0] lane_t;
endpackage

// File: rtl/deser_rr_arbiter.sv
// Four-request round-robin picker that freezes its grant while the consumer stalls.
// Combinational grant/valid from registered requests; lock state updates each edge.
// While valid && !ready the presented grant is held until the handshake or a flush.
module deser_rr_arbiter
    import demux_deser_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [LANES-1:0] req,
    input  lane_t            ptr,
    input  logic             ready,
    output lane_t            grant,
    output logic             valid
);
    logic  lock_vld;
    lane_t lock_lane;
    lane_t last_lane;
    lane_t scan_lane;
    lane_t idx;

    // Walk from the farthest offset down so the lane nearest ptr wins.
    always_comb begin
        scan_lane = ptr;
        idx       = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            idx = ptr + lane_t'(k);
            if (req[idx]) scan_lane = idx;
        end
    end

    assign valid = |req;

    always_comb begin
        grant = last_lane;
        if (valid) grant = lock_vld ? lock_lane : scan_lane;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld  <= 1'b0;
            lock_lane <= '0;
            last_lane <= '0;
        end else begin
            if (valid) last_lane <= grant;
            if (flush) begin
                lock_vld <= 1'b0;
            end else if (valid && !ready) begin
                lock_vld  <= 1'b1;
                lock_lane <= grant;
            end else begin
                lock_vld <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/demux_lane_deserializer.sv
// Rebuilds per-lane MSB-first words from demuxed bits; one held word per lane, round-robin out.
// Latency: last bit sampled at edge N is presented in the cycle after edge N.
// Backpressure: a stalled word stays put; a lane completing onto a full hold drops and sets ovf.
// Optional per-lane drop counters are built when DESER_OVF_COUNT_EN is defined.
module demux_lane_deserializer
    import demux_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  lane_t            sel,
    input  logic [LANES-1:0] lane_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output lane_t            out_lane,
    output logic [WIDTH-1:0] out_data,
    output logic [LANES-1:0] ovf,
    input  logic [LANES-1:0] ovf_clr
`ifdef DESER_OVF_COUNT_EN
    ,
    output logic [8*LANES-1:0] ovf_count
`endif
);
    localparam int CNT_W = $clog2(WIDTH);

    lane_t            rr_ptr;
    lane_t            grant;
    logic             xfer;
    logic [WIDTH-1:0] hold [LANES];
    logic [LANES-1:0] hold_full;
    logic [LANES-1:0] ovf_set;

    assign xfer = out_valid && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-2:0] sreg;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] word;
        logic [WIDTH-1:0] hold_q;
        logic             full_q;
        logic             ovf_q;
        logic             smp;
        logic             last;
        logic             drain;

        assign smp   = bit_valid && (sel == lane_t'(i)) && !flush;
        assign last  = smp && (cnt == CNT_W'(WIDTH - 1));
        assign drain = xfer && (grant == lane_t'(i));
        assign word  = {sreg, lane_in[i]};
        assign ovf_set[i] = last && full_q && !drain;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sreg   <= '0;
                cnt    <= '0;
                hold_q <= '0;
                full_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                if (flush) begin
                    sreg   <= '0;
                    cnt    <= '0;
                    full_q <= 1'b0;
                end else begin
                    if (smp) begin
                        sreg <= word[WIDTH-2:0];
                        cnt  <= last ? '0 : cnt + CNT_W'(1);
                    end
                    // A drain in the same cycle frees the slot for the new word.
                    if (last && (!full_q || drain)) begin
                        hold_q <= word;
                        full_q <= 1'b1;
                    end else if (drain) begin
                        full_q <= 1'b0;
                    end
                end
                ovf_q <= ovf_set[i] | (ovf_q & ~ovf_clr[i]);
            end
        end

        assign hold[i]      = hold_q;
        assign hold_full[i] = full_q;
        assign ovf[i]       = ovf_q;

`ifdef DESER_OVF_COUNT_EN
        logic [7:0] oc_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                oc_q <= '0;
            end else if (ovf_set[i]) begin
                oc_q <= ovf_clr[i] ? 8'd1 : ((oc_q == 8'hFF) ? oc_q : oc_q + 8'd1);
            end else if (ovf_clr[i]) begin
                oc_q <= '0;
            end
        end

        assign ovf_count[8*i +: 8] = oc_q;
`endif
    end

    deser_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .req   (hold_full),
        .ptr   (rr_ptr),
        .ready (out_ready),
        .grant (grant),
        .valid (out_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= grant + lane_t'(1);
        end
    end

    assign out_lane = grant;
    assign out_data = hold[grant];
endmodule

// File: tb/tb_demux_lane_deserializer.sv
// Directed bench for demux_lane_deserializer at WIDTH=8 with hand-computed expectations.
module tb_demux_lane_deserializer;
    logic       clk;
    logic       rst_n;
    logic       bit_valid;
    logic [1:0] sel;
    logic [3:0] lane_in;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_lane;
    logic [7:0] out_data;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;
`ifdef DESER_OVF_COUNT_EN
    logic [31:0] ovf_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    demux_lane_deserializer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (bit_valid),
        .sel       (sel),
        .lane_in   (lane_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane),
        .out_data  (out_data),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`ifdef DESER_OVF_COUNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic [1:0] lane, input logic b);
        logic [3:0] v;
        v = 4'($urandom);
        v[lane] = b;
        lane_in   = v;
        sel       = lane;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [1:0] lane, input logic [7:0] w, input int n);
        for (int k = 7; k > 7 - n; k--) send_bit(lane, w[k]);
    endtask

    initial begin
        logic [7:0] wa;
        logic [7:0] wb;
        rst_n = 1'b0; bit_valid = 1'b0; sel = '0; lane_in = '0;
        flush = 1'b0; out_ready = 1'b0; ovf_clr = '0;

        // Reset state
        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_lane",  32'(out_lane),  0);
        chk("rst_data",  32'(out_data),  0);
        chk("rst_ovf",   32'(ovf),       0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single word on lane 2
        out_ready = 1'b1;
        send_bits(2'd2, 8'hA5, 8);
        chk("a5_valid", 32'(out_valid), 1);
        chk("a5_lane",  32'(out_lane),  2);
        chk("a5_data",  32'(out_data),  32'hA5);
        tick();
        chk("a5_drained", 32'(out_valid), 0);

        // Fresh reset so rr_ptr restarts at 0, then interleave lanes 0 and 3
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        wa = 8'h3C; wb = 8'hC3;
        for (int k = 7; k >= 0; k--) begin
            send_bit(2'd0, wa[k]);
            send_bit(2'd3, wb[k]);
        end
        chk("il_first_lane", 32'(out_lane), 0);
        chk("il_first_data", 32'(out_data), 32'h3C);
        out_ready = 1'b1;
        tick();
        chk("il_second_valid", 32'(out_valid), 1);
        chk("il_second_lane",  32'(out_lane),  3);
        chk("il_second_data",  32'(out_data),  32'hC3);
        tick();
        chk("il_empty", 32'(out_valid), 0);

        // Grant lock: lane 1 stalled while higher-priority lane 0 fills
        out_ready = 1'b0;
        send_bits(2'd1, 8'h5A, 8);
        send_bits(2'd0, 8'h11, 8);
        chk("lock_lane", 32'(out_lane), 1);
        chk("lock_data", 32'(out_data), 32'h5A);
        out_ready = 1'b1;
        tick();
        chk("lock_next_lane", 32'(out_lane), 0);
        chk("lock_next_data", 32'(out_data), 32'h11);
        tick();
        chk("lock_empty", 32'(out_valid), 0);

        // Overflow on lane 2; set beats a simultaneous clear
        out_ready = 1'b0;
        send_bits(2'd2, 8'h96, 8);
        send_bits(2'd2, 8'h69, 8);
        chk("ovf_set",      32'(ovf),      32'h4);
        chk("ovf_kept_dat", 32'(out_data), 32'h96);
        send_bits(2'd2, 8'h33, 7);
        ovf_clr = 4'b0110;
        send_bit(2'd2, 1'b1);
        ovf_clr = 4'b0000;
        chk("ovf_set_wins", 32'(ovf), 32'h4);
        ovf_clr = 4'b0100;
        tick();
        ovf_clr = 4'b0000;
        chk("ovf_cleared", 32'(ovf), 0);
        out_ready = 1'b1;
        chk("ovf_drain_data", 32'(out_data), 32'h96);
        tick();
        chk("ovf_empty", 32'(out_valid), 0);

        // Drain and refill lane 1 in the same cycle
        out_ready = 1'b0;
        send_bits(2'd1, 8'h0F, 8);
        chk("dr_old_lane", 32'(out_lane), 1);
        send_bits(2'd1, 8'hFF, 7);
        out_ready = 1'b1;
        chk("dr_old_data", 32'(out_data), 32'h0F);
        send_bit(2'd1, 1'b1);
        chk("dr_new_valid", 32'(out_valid), 1);
        chk("dr_new_lane",  32'(out_lane),  1);
        chk("dr_new_data",  32'(out_data),  32'hFF);
        chk("dr_no_ovf",    32'(ovf),       0);
        tick();
        chk("dr_empty", 32'(out_valid), 0);

        // Flush discards a partial lane-0 word and a held lane-3 word
        out_ready = 1'b0;
        send_bits(2'd3, 8'hAA, 8);
        chk("fl_held", 32'(out_valid), 1);
        send_bits(2'd0, 8'hFF, 5);
        flush = 1'b1;
        send_bit(2'd0, 1'b1);
        flush = 1'b0;
        chk("fl_valid_clr", 32'(out_valid), 0);
        out_ready = 1'b1;
        send_bits(2'd0, 8'h81, 8);
        chk("fl_word_valid", 32'(out_valid), 1);
        chk("fl_word_lane",  32'(out_lane),  0);
        chk("fl_word_data",  32'(out_data),  32'h81);
        tick();
        chk("fl_empty", 32'(out_valid), 0);
        chk("fl_ovf",   32'(ovf),       0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
